// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution layer sequencing logic.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CONV    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Output dimension for stride 1, no padding.
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

endpackage

// File: rtl/window_counter.sv
// Row/column wrap counter over a ROWS x COLS grid; last_o flags the final cell.
module window_counter #(
  parameter int ROWS = 1,
  parameter int COLS = 1,
  parameter int RW   = 1,
  parameter int CW   = 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  logic row_last;
  logic col_last;

  assign row_last = (row_o == RW'(ROWS - 1));
  assign col_last = (col_o == CW'(COLS - 1));
  assign last_o   = row_last && col_last;

  // Advance column, carry into row, wrap both at the last cell.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      row_o <= '0;
      col_o <= '0;
    end else if (clear_i) begin
      row_o <= '0;
      col_o <= '0;
    end else if (inc_i) begin
      if (col_last) begin
        col_o <= '0;
        row_o <= row_last ? '0 : row_o + RW'(1);
      end else begin
        col_o <= col_o + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Sequences kernel load, window accept and kernel release for one conv layer.
module conv_layer_scheduler
  import cnn_pkg::*;
#(
  parameter int N_CHANNELS   = 1,
  parameter int N_KERNELS    = 32,
  parameter int KERNEL_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  localparam int OUT_W = out_dim(IMAGE_WIDTH, KERNEL_SIZE),
  localparam int OUT_H = out_dim(IMAGE_HEIGHT, KERNEL_SIZE),
  localparam int RW    = $clog2(OUT_H) + 1,
  localparam int CW    = $clog2(OUT_W) + 1,
  localparam int KW    = $clog2(N_KERNELS) + 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [N_CHANNELS-1:0] kernel_valid_i,
  input  logic                  window_valid_i,
  output logic                  kernel_enable_o,
  output logic [N_CHANNELS-1:0] hold_kernel_o,
  output logic                  window_ready_o,
  output logic                  conv_enable_o,
  output logic [RW-1:0]         out_row_o,
  output logic [CW-1:0]         out_col_o,
  output logic [KW-1:0]         out_kernel_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e state_q;
  state_e state_d;
  logic   all_valid;
  logic   win_last;
  logic   kernel_last;
  logic   clear_cnt;

  assign all_valid   = &kernel_valid_i;
  assign kernel_last = (out_kernel_o == KW'(N_KERNELS - 1));
  assign clear_cnt   = (state_q == IDLE) && start_i;

  window_counter #(
    .ROWS(OUT_H),
    .COLS(OUT_W),
    .RW  (RW),
    .CW  (CW)
  ) u_window_counter (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .clear_i(clear_cnt),
    .inc_i  (conv_enable_o),
    .row_o  (out_row_o),
    .col_o  (out_col_o),
    .last_o (win_last)
  );

  // State register.
  always_ff @(posedge clock_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and combinational handshake decode.
  always_comb begin
    state_d         = state_q;
    kernel_enable_o = 1'b0;
    window_ready_o  = 1'b0;
    conv_enable_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        // Drop enable as soon as every channel is valid so the buffer never rereads.
        kernel_enable_o = !all_valid;
        if (all_valid) state_d = CONV;
      end
      CONV: begin
        window_ready_o = 1'b1;
        conv_enable_o  = window_valid_i;
        if (window_valid_i && win_last) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = kernel_last ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered kernel index, hold, busy and done; hold is low only while in RELEASE.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      out_kernel_o  <= '0;
      hold_kernel_o <= '1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      hold_kernel_o <= (state_d == RELEASE) ? '0 : '1;
      busy_o        <= (state_d != IDLE);
      done_o        <= (state_q == RELEASE) && kernel_last;
      if (clear_cnt) begin
        out_kernel_o <= '0;
      end else if (state_q == RELEASE) begin
        out_kernel_o <= kernel_last ? '0 : out_kernel_o + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Scoreboard bench for conv_layer_scheduler: 2-kernel 5x5/K3 layer plus a 1x1 single-kernel layer.
module tb_conv_layer_scheduler;

  localparam int NC = 2;
  localparam int NK = 2;
  localparam int OW = 3;
  localparam int OH = 3;

  logic          clk;
  logic          reset_i;
  logic          start;
  logic [NC-1:0] kv;
  logic          wv;
  logic          kernel_enable;
  logic [NC-1:0] hold;
  logic          window_ready;
  logic          conv_enable;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic [1:0]    out_kernel;
  logic          busy;
  logic          done;

  logic start1;
  logic kv1;
  logic wv1;
  logic kernel_enable1;
  logic hold1;
  logic window_ready1;
  logic conv_enable1;
  logic out_row1;
  logic out_col1;
  logic out_kernel1;
  logic busy1;
  logic done1;

  conv_layer_scheduler #(
    .N_CHANNELS  (NC),
    .N_KERNELS   (NK),
    .KERNEL_SIZE (3),
    .IMAGE_WIDTH (5),
    .IMAGE_HEIGHT(5)
  ) u_dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .start_i        (start),
    .kernel_valid_i (kv),
    .window_valid_i (wv),
    .kernel_enable_o(kernel_enable),
    .hold_kernel_o  (hold),
    .window_ready_o (window_ready),
    .conv_enable_o  (conv_enable),
    .out_row_o      (out_row),
    .out_col_o      (out_col),
    .out_kernel_o   (out_kernel),
    .busy_o         (busy),
    .done_o         (done)
  );

  conv_layer_scheduler #(
    .N_CHANNELS  (1),
    .N_KERNELS   (1),
    .KERNEL_SIZE (3),
    .IMAGE_WIDTH (3),
    .IMAGE_HEIGHT(3)
  ) u_dut1 (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .start_i        (start1),
    .kernel_valid_i (kv1),
    .window_valid_i (wv1),
    .kernel_enable_o(kernel_enable1),
    .hold_kernel_o  (hold1),
    .window_ready_o (window_ready1),
    .conv_enable_o  (conv_enable1),
    .out_row_o      (out_row1),
    .out_col_o      (out_col1),
    .out_kernel_o   (out_kernel1),
    .busy_o         (busy1),
    .done_o         (done1)
  );

  typedef struct {
    int k;
    int r;
    int c;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  int   dones = 0;
  int   hold_lows = 0;
  int   acc_at_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare every accepted window, count done pulses and hold releases.
  always @(negedge clk) begin
    if (reset_i) begin
      if (conv_enable) begin
        accepts++;
        check_eq("accept_has_valid", {31'd0, wv}, 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          check_eq("win_kernel", {30'd0, out_kernel}, e.k);
          check_eq("win_row", {29'd0, out_row}, e.r);
          check_eq("win_col", {29'd0, out_col}, e.c);
        end
      end
      if (done) begin
        dones++;
        acc_at_done = accepts;
      end
      if (hold === '0) hold_lows++;
    end
  end

  task automatic push_layer();
    for (int k = 0; k < NK; k++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          exp_q.push_back('{k: k, r: r, c: c});
  endtask

  task automatic run_layer(input bit toggle);
    int base_acc;
    int base_done;
    int base_hold;
    int n;
    base_acc  = accepts;
    base_done = dones;
    base_hold = hold_lows;
    push_layer();
    wv = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NK; k++) begin
      check_eq("load_enable", {31'd0, kernel_enable}, 32'd1);
      check_eq("load_no_conv", {31'd0, conv_enable}, 32'd0);
      check_eq("load_kernel_idx", {30'd0, out_kernel}, k);
      check_eq("load_row_col", {26'd0, out_row, out_col}, 32'd0);
      check_eq("load_busy", {31'd0, busy}, 32'd1);
      check_eq("load_hold", {30'd0, hold}, 32'd3);
      kv = 2'b01;
      #1 check_eq("enable_partial", {31'd0, kernel_enable}, 32'd1);
      cyc();
      kv = 2'b11;
      #1 check_eq("enable_drop", {31'd0, kernel_enable}, 32'd0);
      cyc();
      n = 0;
      while (hold !== '0 && n < 100) begin
        wv    = toggle ? (n % 2 == 0) : 1'b1;
        start = (!toggle && k == 0 && n == 2);
        cyc();
        n++;
      end
      start = 1'b0;
      if (n >= 100) check_eq("release_timeout", 32'd0, 32'd1);
      wv = 1'b1;
      #1;
      check_eq("release_no_conv", {31'd0, conv_enable}, 32'd0);
      check_eq("release_row_col", {26'd0, out_row, out_col}, 32'd0);
      kv = 2'b00;
      cyc();
    end
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("done_not_busy", {31'd0, busy}, 32'd0);
    check_eq("done_kernel_wrap", {30'd0, out_kernel}, 32'd0);
    check_eq("idle_not_ready", {31'd0, window_ready}, 32'd0);
    wv = 1'b0;
    cyc();
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("layer_accepts", accepts - base_acc, 32'd18);
    check_eq("layer_dones", dones - base_done, 32'd1);
    check_eq("done_after_all", acc_at_done - base_acc, 32'd18);
    check_eq("hold_low_cycles", hold_lows - base_hold, 32'd2);
    check_eq("sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    int acc1;
    reset_i = 1'b0;
    start = 1'b0;
    kv = '0;
    wv = 1'b0;
    start1 = 1'b0;
    kv1 = 1'b1;
    wv1 = 1'b1;
    cyc();
    cyc();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_hold", {30'd0, hold}, 32'd3);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_ready", {31'd0, window_ready}, 32'd0);
    reset_i = 1'b1;
    cyc();

    // Reset in the middle of CONV.
    push_layer();
    wv = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    kv = 2'b11;
    cyc();
    cyc();
    cyc();
    check_eq("midconv_ready", {31'd0, window_ready}, 32'd1);
    reset_i = 1'b0;
    cyc();
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_hold", {30'd0, hold}, 32'd3);
    check_eq("midrst_row_col", {26'd0, out_row, out_col}, 32'd0);
    check_eq("midrst_kernel", {30'd0, out_kernel}, 32'd0);
    check_eq("midrst_ready", {31'd0, window_ready}, 32'd0);
    check_eq("midrst_kenable", {31'd0, kernel_enable}, 32'd0);
    reset_i = 1'b1;
    kv = '0;
    wv = 1'b0;
    exp_q.delete();
    cyc();

    run_layer(1'b0);
    run_layer(1'b1);

    // Single kernel, 1x1 output, kernel already valid.
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    n = 1;
    acc1 = 0;
    while (!done1 && n < 20) begin
      acc1 += conv_enable1 ? 1 : 0;
      if (n == 1) begin
        check_eq("s1_load_busy", {31'd0, busy1}, 32'd1);
        check_eq("s1_load_kenable", {31'd0, kernel_enable1}, 32'd0);
      end
      if (n == 2) check_eq("s1_conv_rc", {30'd0, out_row1, out_col1}, 32'd0);
      if (n == 3) check_eq("s1_release_hold", {31'd0, hold1}, 32'd0);
      cyc();
      n++;
    end
    check_eq("s1_cycles_to_done", n, 32'd4);
    check_eq("s1_accepts", acc1, 32'd1);
    check_eq("s1_idle_busy", {31'd0, busy1}, 32'd0);
    check_eq("s1_idle_hold", {31'd0, hold1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
